hpi_txn_ctrl: RTL
=================

HPI_TXN_CTRL -- requirements
Module: hpi_txn_ctrl

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 4: cycles RD/WR strobe is held low per access, legal range 2..15.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2: idle cycles after each strobe, legal range 1..15.
REQ-003 SHALL have parameter RST_CYCLES, default 16: cycles the chip reset is held low, legal range 1..255.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports Clk and Reset are named as the codebase names them.
REQ-005 SHALL have ports (name direction width meaning):
  Clk  in  1  clock
  Reset  in  1  synchronous active-high reset
  req_valid  in  1  transaction request
  req_ready  out  1  high only in IDLE
  req_write  in  1  1 = write, 0 = read
  req_addr  in  16  EZ-OTG internal address
  req_wdata  in  16  write data
  rst_req  in  1  one-cycle pulse requesting a chip reset
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  16  read data, 0 for writes
  busy  out  1  high in any state other than IDLE
  hpi_addr  out  2  HPI register select toward the I/O interface
  hpi_data_out  out  16  write data toward the I/O interface
  hpi_data_in  in  16  registered bus data from the I/O interface
  hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n  out  1 each  active-low strobes toward the I/O interface

Function
REQ-006 SHALL implement states IDLE, CRST, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, RESP.
REQ-007 SHALL accept a request on the edge where req_valid && req_ready, latch req_write/addr/wdata, and go to A_SETUP.
REQ-008 Address phase SHALL write the latched req_addr to HPI register 2'b10; data phase SHALL access HPI register 2'b00.
REQ-009 *_SETUP SHALL last 1 cycle with hpi_cs_n=0, hpi_addr and hpi_data_out valid, and hpi_r_n=hpi_w_n=1.
REQ-010 *_STROBE SHALL last STROBE_CYCLES with hpi_cs_n=0 and hpi_w_n=0 (write access) or hpi_r_n=0 (read access).
REQ-011 *_RECOV SHALL last RECOVER_CYCLES with hpi_cs_n=hpi_r_n=hpi_w_n=1; hpi_addr and hpi_data_out SHALL be held unchanged.
REQ-012 On a read, resp_rdata SHALL capture hpi_data_in in the first D_RECOV cycle, compensating for the I/O interface's one-cycle register delay.
REQ-013 RESP SHALL last 1 cycle with resp_valid=1, then return to IDLE; there is no response backpressure.
REQ-014 Latency SHALL be exactly 2*(1+STROBE_CYCLES+RECOVER_CYCLES)+1 cycles from the accept edge to resp_valid, which is 15 at default parameters.
REQ-015 rst_req in IDLE SHALL enter CRST, drive hpi_rst_n=0 for RST_CYCLES with cs/r/w high, then return to IDLE without asserting resp_valid.
REQ-016 If rst_req and req_valid are both high in IDLE, rst_req SHALL win and the request SHALL NOT be accepted.
REQ-017 rst_req and req_valid outside IDLE SHALL be ignored.
REQ-018 The phase counter SHALL be 8 bits wide, reload on each state entry, and never wrap.

Reset
REQ-019 Reset SHALL force IDLE on the next edge, including mid-transaction, with no resp_valid for the aborted transaction.
REQ-020 Reset values SHALL be hpi_cs_n=hpi_r_n=hpi_w_n=hpi_rst_n=1, hpi_addr=0, hpi_data_out=0, resp_valid=0, resp_rdata=0, busy=0, and req_ready=0 while Reset is high.
REQ-021 req_ready SHALL be 1 in the first cycle after Reset deasserts.

Configuration
REQ-022 With macro HPI_TXN_COUNT_EN defined, an output txn_count[15:0] SHALL increment on each resp_valid, wrap at 0xFFFF->0, and reset to 0.
REQ-023 Without HPI_TXN_COUNT_EN, the txn_count port SHALL still exist and be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-024 Write req_addr=0x1234, req_wdata=0xBEEF at defaults -> hpi_addr=2, data 0x1234 with hpi_w_n low 4 cycles; then hpi_addr=0, data 0xBEEF with hpi_w_n low 4 cycles; resp_valid at cycle 15, resp_rdata=0.
REQ-025 Read req_addr=0x0140 with the bench returning hpi_data_in=0xA5A5 during the D_STROBE window -> resp_rdata=0xA5A5 at cycle 15.
REQ-026 rst_req and req_valid high in the same IDLE cycle -> hpi_rst_n low exactly 16 cycles, no request accepted, then req_ready=1.
REQ-027 Reset asserted during D_STROBE of a write -> next cycle hpi_w_n=1, hpi_cs_n=1, state IDLE, no resp_valid.
REQ-028 Back-to-back requests with req_valid held high -> second accept exactly one cycle after the first resp_valid; with HPI_TXN_COUNT_EN, txn_count=2.

Source files
------------

// File: rtl/hpi_txn_ctrl.sv
// hpi_txn_ctrl -- transaction controller for an EZ-OTG style HPI port.
//
// Each accepted request becomes two HPI accesses:
//    1. address phase: write the latched req_addr to HPI register 2'b10
//    2. data phase:    read or write HPI register 2'b00
// Each access runs SETUP (1 cycle), STROBE (STROBE_CYCLES) and
// RECOV (RECOVER_CYCLES). A one-cycle RESP state then pulses resp_valid.
// rst_req in IDLE holds hpi_rst_n low for RST_CYCLES instead.
//
// Ports:
//    Clk, Reset                     clock, synchronous active-high reset
//    req_valid/req_ready            request handshake (ready only in IDLE)
//    req_write, req_addr, req_wdata request contents
//    rst_req                        chip reset request pulse
//    resp_valid, resp_rdata         completion pulse and read data
//    busy                           high whenever not IDLE
//    hpi_addr, hpi_data_out         register select and write data to the I/O block
//    hpi_data_in                    registered bus data from the I/O block
//    hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n  active-low strobes
//    txn_count                      completed transaction count
//
// Build option: define HPI_TXN_COUNT_EN to make txn_count count resp_valid
// pulses; otherwise txn_count is tied to 0.
module hpi_txn_ctrl #(
   parameter int STROBE_CYCLES  = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int RST_CYCLES     = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic        rst_req,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        busy,
   output logic [1:0]  hpi_addr,
   output logic [15:0] hpi_data_out,
   input  logic [15:0] hpi_data_in,
   output logic        hpi_r_n,
   output logic        hpi_w_n,
   output logic        hpi_cs_n,
   output logic        hpi_rst_n,
   output logic [15:0] txn_count
);

   typedef enum logic [3:0] {
      IDLE, CRST, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, RESP
   } state_t;

   // Counter reload values: a state lasting N cycles loads N-1 and leaves at 0.
   localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYCLES - 1);
   localparam logic [7:0] RST_LD     = 8'(RST_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        accept;
   logic        write_reg;
   logic [15:0] wdata_reg;
   logic [1:0]  addr_out_reg;
   logic [15:0] data_out_reg;
   logic [15:0] rdata_reg;

   assign req_ready = (state_reg == IDLE) && !Reset;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      // Saturating down-count; states reload on entry below.
      cnt_next   = (cnt_reg != 8'd0) ? cnt_reg - 8'd1 : cnt_reg;
      case (state_reg)
         IDLE: begin
            // rst_req has priority over a simultaneous request.
            if (rst_req) begin
               state_next = CRST;
               cnt_next   = RST_LD;
            end else if (accept) begin
               state_next = A_SETUP;
               cnt_next   = 8'd0;
            end
         end
         CRST:     if (cnt_reg == 8'd0) state_next = IDLE;
         A_SETUP: begin
            state_next = A_STROBE;
            cnt_next   = STROBE_LD;
         end
         A_STROBE: if (cnt_reg == 8'd0) begin
            state_next = A_RECOV;
            cnt_next   = RECOVER_LD;
         end
         A_RECOV:  if (cnt_reg == 8'd0) begin
            state_next = D_SETUP;
            cnt_next   = 8'd0;
         end
         D_SETUP: begin
            state_next = D_STROBE;
            cnt_next   = STROBE_LD;
         end
         D_STROBE: if (cnt_reg == 8'd0) begin
            state_next = D_RECOV;
            cnt_next   = RECOVER_LD;
         end
         D_RECOV:  if (cnt_reg == 8'd0) begin
            state_next = RESP;
            cnt_next   = 8'd0;
         end
         RESP:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Request latch and HPI address/data drive. The address/data registers
   // only change at phase start, so they stay stable through RECOV.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         write_reg    <= 1'b0;
         wdata_reg    <= 16'h0000;
         addr_out_reg <= 2'b00;
         data_out_reg <= 16'h0000;
         rdata_reg    <= 16'h0000;
      end else begin
         if (accept && !rst_req) begin
            write_reg    <= req_write;
            wdata_reg    <= req_wdata;
            addr_out_reg <= 2'b10;
            data_out_reg <= req_addr;
            rdata_reg    <= 16'h0000;
         end
         if (state_reg == A_RECOV && state_next == D_SETUP) begin
            addr_out_reg <= 2'b00;
            data_out_reg <= write_reg ? wdata_reg : 16'h0000;
         end
         // hpi_data_in lags the bus by one register stage, so the last
         // strobe cycle's data shows up in the first D_RECOV cycle.
         if (state_reg == D_RECOV && cnt_reg == RECOVER_LD && !write_reg)
            rdata_reg <= hpi_data_in;
      end
   end

   assign hpi_addr     = addr_out_reg;
   assign hpi_data_out = data_out_reg;
   assign resp_rdata   = rdata_reg;
   assign resp_valid   = (state_reg == RESP);
   assign busy         = (state_reg != IDLE);

   assign hpi_cs_n  = !(state_reg == A_SETUP || state_reg == A_STROBE ||
                        state_reg == D_SETUP || state_reg == D_STROBE);
   // Address phase is always a write of the target address.
   assign hpi_w_n   = !(state_reg == A_STROBE || (state_reg == D_STROBE && write_reg));
   assign hpi_r_n   = !(state_reg == D_STROBE && !write_reg);
   assign hpi_rst_n = !(state_reg == CRST);

`ifdef HPI_TXN_COUNT_EN
   logic [15:0] count_reg;

   always_ff @(posedge Clk) begin
      if (Reset)
         count_reg <= 16'h0000;
      else if (state_reg == RESP)
         count_reg <= count_reg + 16'h0001;
   end

   assign txn_count = count_reg;
`else
   assign txn_count = 16'h0000;
`endif

endmodule
